// File: rtl/fp_mac_ctrl.sv
// Dot-product sequencer for an external 1-cycle FP multiplier and FP adder; accumulates in_a*in_b over len pairs.
// Latency: result valid 3 cycles after the last input handshake; holds the result until out_ready; one pair per cycle.
module fp_mac_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_p,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             v1;
  logic             v2;
  logic             hs;

  assign hs = in_valid && in_ready;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (hs) begin
      mul_a = in_a;
      mul_b = in_b;
    end
  end

  // Zero operands outside RUN/DRAIN flush the adder register, so each job starts from +0.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == RUN || state == DRAIN) begin
      add_a = v1 ? mul_p : '0;
      add_b = add_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      v1 <= hs;
      v2 <= v1;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state     <= RUN;
              remaining <= len;
              v1        <= 1'b0;
              v2        <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              state     <= DONE;
              out_data  <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // v2 without v1: the final product went through the adder last cycle.
          if (v2 && !v1) begin
            out_data  <= add_s;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mac_ctrl.sv
// Directed bench for fp_mac_ctrl; models the external registered FP multiplier and adder behaviourally.
module tb_fp_mac_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [31:0] add_a, add_b, add_s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int hs_cyc = 0;

  fp_mac_ctrl #(.WIDTH(32), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0 + 0.5))};
  endfunction

  // External arithmetic units: registered, never reset, so stale contents survive a DUT reset.
  always @(posedge clk) begin
    mul_p <= r2fp(fp2r(mul_a) * fp2r(mul_b));
    add_s <= r2fp(fp2r(add_a) + fp2r(add_b));
    cyc   <= cyc + 1;
    if (in_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
    if (l != 8'd0) begin
      chk("run_in_ready", 32'(in_ready), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
    end
  endtask

  // Leaves in_valid high so consecutive calls are back-to-back.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int g;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    g = 0;
    while (!in_ready && g < 20) begin step(); g++; end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    hs_cyc = cyc;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_a = 32'h0;
    in_b = 32'h0;
    repeat (n) step();
  endtask

  task automatic finish_job(input string tag, input logic [31:0] exp, input int hold);
    int g;
    g = 0;
    while (!out_valid && g < 20) begin step(); g++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - hs_cyc), 32'd3);
    chk({tag, "_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      start = (i == 2);
      len   = 8'd3;
      step();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int r0;
    reset = 1'b1;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    in_a = 32'h0;
    in_b = 32'h0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    reset = 1'b0;
    step();

    // 1*2 + 3*4 = 14, back-to-back
    start_job(8'd2);
    send(32'h3F800000, 32'h40000000);
    send(32'h40400000, 32'h40800000);
    idle(0);
    finish_job("basic", 32'h41600000, 0);
    step();

    // Same pairs with three bubbles between them
    start_job(8'd2);
    send(32'h3F800000, 32'h40000000);
    idle(3);
    send(32'h40400000, 32'h40800000);
    idle(0);
    finish_job("bubbles", 32'h41600000, 0);
    step();

    // Empty job
    r0 = rdy_cnt;
    start_job(8'd0);
    chk("empty_valid", 32'(out_valid), 32'd1);
    chk("empty_data", out_data, 32'h0);
    chk("empty_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("empty_idle_valid", 32'(out_valid), 32'd0);
    chk("empty_no_in_ready", 32'(rdy_cnt - r0), 32'd0);

    // 1*2 + (-1)*1 = 1, held under backpressure with a start pulse in DONE
    start_job(8'd2);
    send(32'h3F800000, 32'h40000000);
    send(32'hBF800000, 32'h3F800000);
    idle(0);
    finish_job("neg", 32'h3F800000, 5);
    step();
    chk("neg_start_ignored_busy", 32'(busy), 32'd0);
    chk("neg_start_ignored_rdy", 32'(in_ready), 32'd0);

    // Reset in the middle of a 4-pair job
    start_job(8'd4);
    send(32'h40400000, 32'h40400000);
    send(32'h40400000, 32'h40400000);
    idle(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_data", out_data, 32'h0);
    start_job(8'd1);
    send(32'h40000000, 32'h40000000);
    idle(0);
    finish_job("after_rst", 32'h40800000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_mac_ctrl.md
FP_MAC_CTRL -- requirements
Module: fp_mac_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sets the IEEE 754 single-precision operand and result width.
REQ-002 Parameter LEN_W, default 8, sets the width of the element-count input.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  job request; sampled only in IDLE.
REQ-007 len  in  LEN_W  number of element pairs in the job; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 in_valid  in  1  an element pair is present on in_a/in_b.
REQ-010 in_ready  out  1  controller accepts a pair this cycle.
REQ-011 in_a, in_b  in  WIDTH each  element pair (FP32).
REQ-012 mul_a, mul_b  out  WIDTH each  operands to the external 1-cycle registered FP multiplier.
REQ-013 mul_p  in  WIDTH  multiplier result; corresponds to the operands driven one cycle earlier.
REQ-014 add_a, add_b  out  WIDTH each  operands to the external 1-cycle registered FP adder.
REQ-015 add_s  in  WIDTH  adder result; corresponds to the operands driven one cycle earlier.
REQ-016 out_valid  out  1  dot-product result is available.
REQ-017 out_ready  in  1  consumer accepts the result.
REQ-018 out_data  out  WIDTH  registered result: sum over the job of in_a*in_b.

Function
REQ-019 The FSM shall have exactly these states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE, start=1, len>0 -> RUN: load remaining counter with len; clear pipeline valid bits v1 and v2.
REQ-021 IDLE, start=1, len=0 -> DONE: load out_data with 32'h00000000.
REQ-022 start shall be ignored in RUN, DRAIN and DONE.
REQ-023 in_ready shall be 1 only in RUN; a handshake is in_valid and in_ready both high.
REQ-024 On a handshake: mul_a=in_a and mul_b=in_b (combinational); otherwise mul_a=mul_b=0.
REQ-025 On a handshake: remaining decrements by 1 and v1 is set for the next cycle; otherwise v1 clears. v2 is v1 delayed one cycle.
REQ-026 When the handshake takes remaining from 1 to 0, the FSM shall go to DRAIN in the next cycle.
REQ-027 In IDLE: add_a=add_b=0, so add_s is +0 when RUN begins.
REQ-028 In RUN and DRAIN: add_a = v1 ? mul_p : 0; add_b = add_s. The adder's zero bypass therefore holds the accumulator through bubbles.
REQ-029 DRAIN shall last exactly 2 cycles. On the second cycle, out_data shall capture add_s and the FSM shall go to DONE.
REQ-030 Latency: last handshake in cycle t -> out_valid high in cycle t+3.
REQ-031 Throughput: one pair per cycle; in_valid bubbles in RUN shall not corrupt the sum.
REQ-032 DONE: out_valid=1 and out_data stable until out_valid and out_ready are both high.
REQ-033 DONE with out_valid and out_ready high -> IDLE in the next cycle.
REQ-034 out_valid shall be 0 in every state other than DONE.

Reset
REQ-035 When reset=1 at a clock edge, in any state including mid-job:
- FSM -> IDLE
- remaining, v1, v2 cleared
- out_valid=0, out_data=0, busy=0, in_ready=0
REQ-036 Stale values in the external Mul/Add registers after reset shall not affect the next job (guaranteed by REQ-027).

Verification
REQ-037 Basic job: start with len=2; pairs (3F800000,40000000) and (40400000,40800000) back-to-back.
- out_data=41600000 (14.0).
- out_valid 3 cycles after the second handshake.
REQ-038 Bubbles: same pairs with 3 idle cycles of in_valid=0 between them -> out_data=41600000.
REQ-039 Empty job: start with len=0 -> out_valid next cycle, out_data=00000000, no in_ready pulse.
REQ-040 Backpressure and ignored start:
- hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable throughout.
- pulse start during DONE -> ignored.
- release out_ready -> IDLE next cycle.
REQ-041 Reset mid-job: len=4, reset after 2 handshakes -> IDLE, out_valid=0. New job len=1 with (40000000,40000000) -> out_data=40800000.
REQ-042 Negative operand: len=2 with (3F800000,40000000) and (BF800000,3F800000) -> out_data=3F800000.
